// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard detection / forwarding unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0]  RESULT_LOAD = 2'b01;
  localparam logic [31:0] REG_ZERO    = '0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline event statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding unit for the 5-stage RISC-V pipeline.
// Tracks its own copy of E/M/W destination info so it only needs decode inputs.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] Rd_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       ResultSrc_D,
  input  logic             PCSrc_E,
  input  logic             cnt_clr,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_ZERO[REG_W-1:0];

  logic [REG_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic [1:0]       result_src_e;
  logic             lw_stall;
  fwd_sel_t         fwd_a, fwd_b;

  // A load in execute whose destination is read by decode must hold decode one cycle.
  always_comb begin
    lw_stall = (result_src_e == RESULT_LOAD) && (rd_e != ZERO_IDX) &&
               ((Rs1_D == rd_e) || (Rs2_D == rd_e));
  end

  assign Stall_F = lw_stall & ~PCSrc_E;
  assign Stall_D = lw_stall & ~PCSrc_E;
  assign Flush_D = PCSrc_E;
  assign Flush_E = lw_stall | PCSrc_E;

  // Operand bypass select: memory stage holds the newer value, so it wins over writeback.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (reg_write_m && (rd_m != ZERO_IDX) && (rs1_e == rd_m)) begin
      fwd_a = FWD_MEM;
    end else if (reg_write_w && (rd_w != ZERO_IDX) && (rs1_e == rd_w)) begin
      fwd_a = FWD_WB;
    end
    if (reg_write_m && (rd_m != ZERO_IDX) && (rs2_e == rd_m)) begin
      fwd_b = FWD_MEM;
    end else if (reg_write_w && (rd_w != ZERO_IDX) && (rs2_e == rd_w)) begin
      fwd_b = FWD_WB;
    end
  end

  assign ForwardA_E = fwd_a;
  assign ForwardB_E = fwd_b;

  // Shadow pipeline: a flush drops a bubble into E; M and W always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      result_src_e <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      if (Flush_E) begin
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        reg_write_e  <= 1'b0;
        result_src_e <= '0;
      end else begin
        rs1_e        <= Rs1_D;
        rs2_e        <= Rs2_D;
        rd_e         <= Rd_D;
        reg_write_e  <= RegWrite_D;
        result_src_e <= ResultSrc_D;
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Stall_D),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (PCSrc_E),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic
// compared against an instruction-level pipeline model.
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int REG_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] Rs1_D, Rs2_D, Rd_D;
  logic             RegWrite_D;
  logic [1:0]       ResultSrc_D;
  logic             PCSrc_E;
  logic             cnt_clr;
  logic             Stall_F, Stall_D, Flush_D, Flush_E;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // One instruction as it sits in a pipeline stage of the model.
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    int we;
    int rsrc;
  } instr_t;

  instr_t in_e, in_m, in_w;
  int     model_stall_cnt;
  int     model_flush_cnt;

  hazard_unit #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rd_D        (Rd_D),
    .RegWrite_D  (RegWrite_D),
    .ResultSrc_D (ResultSrc_D),
    .PCSrc_E     (PCSrc_E),
    .cnt_clr     (cnt_clr),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.we = 0; b.rsrc = 0;
    return b;
  endfunction

  // Where should an execute operand reading register r get its value from?
  function automatic int expectedForward(input int r);
    if (r == 0) return 0;
    if (in_m.we != 0 && in_m.rd == r) return 2;
    if (in_w.we != 0 && in_w.rd == r) return 1;
    return 0;
  endfunction

  function automatic void modelReset();
    in_e = bubble();
    in_m = bubble();
    in_w = bubble();
    model_stall_cnt = 0;
    model_flush_cnt = 0;
  endfunction

  // Present one decode instruction for one cycle, check all outputs mid-cycle,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input int rs1, input int rs2, input int rd, input int we,
                               input int rsrc, input int pc, input int clr);
    int     lu;
    int     st;
    int     fe;
    instr_t d;
    Rs1_D       = REG_W'(rs1);
    Rs2_D       = REG_W'(rs2);
    Rd_D        = REG_W'(rd);
    RegWrite_D  = 1'(we);
    ResultSrc_D = 2'(rsrc);
    PCSrc_E     = 1'(pc);
    cnt_clr     = 1'(clr);
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.we = we; d.rsrc = rsrc;

    lu = (in_e.rsrc == 1 && in_e.rd != 0 && (rs1 == in_e.rd || rs2 == in_e.rd)) ? 1 : 0;
    st = (lu == 1 && pc == 0) ? 1 : 0;
    fe = (lu == 1 || pc == 1) ? 1 : 0;

    @(negedge clk);
    checkOutput("Stall_F", int'(Stall_F), st);
    checkOutput("Stall_D", int'(Stall_D), st);
    checkOutput("Flush_D", int'(Flush_D), pc);
    checkOutput("Flush_E", int'(Flush_E), fe);
    checkOutput("ForwardA_E", int'(ForwardA_E), expectedForward(in_e.rs1));
    checkOutput("ForwardB_E", int'(ForwardB_E), expectedForward(in_e.rs2));
    checkOutput("stall_cnt", int'(stall_cnt), model_stall_cnt);
    checkOutput("flush_cnt", int'(flush_cnt), model_flush_cnt);

    @(posedge clk);
    in_w = in_m;
    in_m = in_e;
    in_e = (fe == 1) ? bubble() : d;
    if (clr == 1) begin
      model_stall_cnt = 0;
      model_flush_cnt = 0;
    end else begin
      if (st == 1 && model_stall_cnt < CNT_MAX) model_stall_cnt++;
      if (pc == 1 && model_flush_cnt < CNT_MAX) model_flush_cnt++;
    end
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_Stall_F"}, int'(Stall_F), 0);
    checkOutput({tag, "_Stall_D"}, int'(Stall_D), 0);
    checkOutput({tag, "_Flush_E"}, int'(Flush_E), 0);
    checkOutput({tag, "_FwdA"}, int'(ForwardA_E), 0);
    checkOutput({tag, "_FwdB"}, int'(ForwardB_E), 0);
    checkOutput({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    checkOutput({tag, "_flush_cnt"}, int'(flush_cnt), 0);
  endtask

  initial begin
    reset       = 1'b0;
    Rs1_D       = '0;
    Rs2_D       = '0;
    Rd_D        = '0;
    RegWrite_D  = 1'b0;
    ResultSrc_D = '0;
    PCSrc_E     = 1'b0;
    cnt_clr     = 1'b0;
    modelReset();

    #3;
    checkAllZero("in_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("in_reset2");
    reset = 1'b1;

    // First cycle after release: everything idle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Load-use on x5, stall, re-present, then consumer sees load in W.
    applyStimulus(0, 0, 5, 1, 1, 0, 0);
    applyStimulus(5, 0, 6, 1, 0, 0, 0);
    applyStimulus(5, 0, 6, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // ALU back-to-back on x3 (M forward), then two apart (W forward).
    applyStimulus(1, 2, 3, 1, 0, 0, 0);
    applyStimulus(0, 3, 4, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 3, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 3, 4, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // x7 written twice in a row; the consumer must take the newer (M) copy.
    applyStimulus(0, 0, 7, 1, 0, 0, 0);
    applyStimulus(0, 0, 7, 1, 0, 0, 0);
    applyStimulus(7, 7, 8, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Load into x0 never stalls or forwards.
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 9, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Branch resolves while a load-use condition is present.
    applyStimulus(0, 0, 10, 1, 1, 0, 0);
    applyStimulus(0, 10, 11, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Flush counter saturation, then clear racing an increment.
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("flush_sat", int'(flush_cnt), CNT_MAX);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    // Reset pulled low in the middle of a load-use stall.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 12, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 12, 1, 1, 0, 0);
    Rs1_D       = 5'd12;
    Rs2_D       = '0;
    Rd_D        = 5'd13;
    RegWrite_D  = 1'b1;
    ResultSrc_D = '0;
    PCSrc_E     = 1'b0;
    cnt_clr     = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_stall", int'(Stall_D), 1);
    #1;
    reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(12, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
